// File: rtl/load_store_unit.sv
// Single-access load/store unit: decodes size/alignment, drives a ready-handshaked
// word memory and returns extended load data with a one-cycle done pulse.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        whb,
    input  logic              su,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             ld_q, su_q, err_q;
    logic [1:0]       whb_q, off_q;
    logic             illegal, timeout_hit;
    logic [3:0]       be_dec;
    logic [31:0]      wrep;

    // Pick the addressed lane and sign- or zero-extend it; word loads ignore su.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_ext = sx ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   load_ext = sx ? {{16{h[15]}}, h} : {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        illegal = (whb == 2'b11) || (whb == 2'b01 && addr[0]) || (whb == 2'b10 && addr[1:0] != 2'b00);
        case (whb)
            2'b00: begin
                be_dec = 4'b0001 << addr[1:0];
                wrep   = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_dec = 4'b0011 << {addr[1], 1'b0};
                wrep   = {2{wdata[15:0]}};
            end
            default: begin
                be_dec = 4'b1111;
                wrep   = wdata;
            end
        endcase
    end

    assign timeout_hit = !mem_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = illegal ? DONE : REQ;
            REQ:     if (mem_ready || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_q      <= 1'b0;
            su_q      <= 1'b0;
            err_q     <= 1'b0;
            whb_q     <= 2'b00;
            off_q     <= 2'b00;
            rdata     <= 32'h0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        ld_q  <= rw;
                        su_q  <= su;
                        whb_q <= whb;
                        off_q <= addr[1:0];
                        err_q <= illegal;
                        if (illegal) begin
                            rdata <= 32'h0;
                        end else begin
                            // Memory outputs are frozen here and held for the whole REQ phase.
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= be_dec;
                            mem_wdata <= rw ? 32'h0 : wrep;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        rdata <= ld_q ? load_ext(mem_rdata, whb_q, su_q, off_q) : 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                            rdata <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall   = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = done & err_q;
    assign mem_req = (state == REQ);
    assign mem_we  = mem_req & ~ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at start
// and compared by a monitor when done pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rw, su;
    logic [1:0]  whb;
    logic [31:0] addr, wdata;
    logic        stall, done, err, mem_req, mem_we, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        ready_en;

    typedef struct packed {
        logic        e;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_ready = mem_req & ready_en;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .whb(whb), .su(su),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("err", {31'h0, err}, {31'h0, x.e});
                chk("rdata", rdata, x.rd);
            end
        end
    end

    task automatic access(input string tag, input logic r, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mword,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int k;
        @(negedge clk);
        start = 1'b1; rw = r; whb = w; su = s; addr = a; wdata = wd; mem_rdata = mword;
        sb.push_back('{e: exp_err, rd: exp_rd});
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_stall"}, {31'h0, stall}, 32'd1);
        if (exp_err) begin
            chk({tag, "_noreq"}, {31'h0, mem_req}, 32'd0);
            chk({tag, "_done_n1"}, {31'h0, done}, 32'd1);
        end else begin
            chk({tag, "_req"}, {31'h0, mem_req}, 32'd1);
            chk({tag, "_we"}, {31'h0, mem_we}, {31'h0, ~r});
            chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
            k = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk({tag, "_latency"}, k, 1);
        end
    endtask

    initial begin
        int k, reqc;
        rst = 1'b1; start = 1'b0; rw = 1'b0; whb = 2'b00; su = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; ready_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_req", {31'h0, mem_req}, 32'd0);
        chk("rst_we", {31'h0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mbe", {28'h0, mem_be}, 32'h0);
        chk("rst_mwd", mem_wdata, 32'h0);
        rst = 1'b0;

        access("lw",   1, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
        @(negedge clk);
        chk("hold_rdata", rdata, 32'hDEADBEEF);
        chk("idle_stall", {31'h0, stall}, 32'd0);
        access("lb",   1, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
        access("lbu",  1, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0, 32'h00000080, 4'b1000, 32'h0);
        access("lh",   1, 2'b01, 1, 32'h102, 32'h0, 32'h80112233, 0, 32'hFFFF8011, 4'b1100, 32'h0);
        access("lhu",  1, 2'b01, 0, 32'h100, 32'h0, 32'h8011A233, 0, 32'h0000A233, 4'b0011, 32'h0);
        access("lw_su",1, 2'b10, 1, 32'h10C, 32'h0, 32'h7F00FF01, 0, 32'h7F00FF01, 4'b1111, 32'h0);
        access("sh",   0, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 32'h0, 4'b1100, 32'hABCDABCD);
        access("sw",   0, 2'b10, 0, 32'h204, 32'hCAFEF00D, 32'h0, 0, 32'h0, 4'b1111, 32'hCAFEF00D);
        access("lw_mis",1, 2'b10, 0, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
        access("sb",   0, 2'b00, 0, 32'h101, 32'h000000A5, 32'h0, 0, 32'h0, 4'b0010, 32'hA5A5A5A5);
        access("lh_mis",1, 2'b01, 1, 32'h103, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
        access("rsv",  1, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0);

        // Timeout with start pulses arriving while the access is in flight.
        ready_en = 1'b0;
        @(negedge clk);
        start = 1'b1; rw = 1'b1; whb = 2'b10; su = 1'b0; addr = 32'h300;
        sb.push_back('{e: 1'b1, rd: 32'h0});
        @(negedge clk);
        reqc = 0;
        k = 0;
        while (!done && k < 20) begin
            if (mem_req) reqc++;
            start = (k < 2);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("to_req_cycles", reqc, 4);
        chk("to_req_at_done", {31'h0, mem_req}, 32'd0);
        @(negedge clk);
        chk("to_idle_stall", {31'h0, stall}, 32'd0);
        @(negedge clk);
        chk("to_no_queued", {31'h0, done | stall}, 32'd0);

        // Reset in the middle of an access.
        @(negedge clk);
        start = 1'b1; rw = 1'b1; whb = 2'b10; addr = 32'h400;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", {31'h0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", {31'h0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'h0, stall}, 32'd0);
        chk("mid_rst_done", {31'h0, done}, 32'd0);
        rst = 1'b0;
        ready_en = 1'b1;
        access("lw_post", 1, 2'b10, 0, 32'h400, 32'h0, 32'h13579BDF, 0, 32'h13579BDF, 4'b1111, 32'h0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
